// File: rtl/traffic_pkg.sv
// Shared encodings for the lamp-output conflict monitor: aspects, tracker states,
// fault codes and anomaly indices, plus small decode helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    ASP_R     = 3'd0,
    ASP_Y     = 3'd1,
    ASP_G     = 3'd2,
    ASP_DARK  = 3'd3,
    ASP_MULTI = 3'd4
  } aspect_e;

  typedef enum logic [1:0] {
    TRK_UNK = 2'd0,
    TRK_RED = 2'd1,
    TRK_YEL = 2'd2,
    TRK_GRN = 2'd3
  } trk_state_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_CONFLICT = 3'd1,
    FC_MULTI    = 3'd2,
    FC_DARK     = 3'd3,
    FC_SEQ      = 3'd4,
    FC_SHORT_Y  = 3'd5
  } fault_code_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam int unsigned AN_CONFLICT = 0;
  localparam int unsigned AN_MULTI    = 1;
  localparam int unsigned AN_DARK     = 2;
  localparam int unsigned AN_NUM      = 3;

  function automatic aspect_e decode_aspect(input lamp_t l);
    case ({l.red, l.yellow, l.green})
      3'b100:  return ASP_R;
      3'b010:  return ASP_Y;
      3'b001:  return ASP_G;
      3'b000:  return ASP_DARK;
      default: return ASP_MULTI;
    endcase
  endfunction

  function automatic trk_state_e aspect_to_state(input aspect_e a);
    case (a)
      ASP_R:   return TRK_RED;
      ASP_Y:   return TRK_YEL;
      ASP_G:   return TRK_GRN;
      default: return TRK_UNK;
    endcase
  endfunction

  // Only the controller's forward cycle G->Y->R->G is a legal aspect change.
  function automatic logic is_legal_step(input trk_state_e from_s, input trk_state_e to_s);
    return ((from_s == TRK_GRN) && (to_s == TRK_YEL)) ||
           ((from_s == TRK_YEL) && (to_s == TRK_RED)) ||
           ((from_s == TRK_RED) && (to_s == TRK_GRN));
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp inputs, operator clear and fault outputs of the conflict monitor.
interface traffic_conflict_monitor_if;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_en;
  logic       monitor_ok;

  modport master (
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clr,
    input  fault, fault_code, flash_en, monitor_ok
  );

  modport slave (
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clr,
    output fault, fault_code, flash_en, monitor_ok
  );
endinterface

// File: rtl/traffic_approach_tracker.sv
// One approach: aspect decode, R/Y/G sequence tracker and yellow-duration counter.
// Detections are presented combinationally and latched by the fault register above.
module traffic_approach_tracker
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_MIN = 500,
  parameter int unsigned CWIDTH     = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_clr,
  input  lamp_t   i_lamp,
  output aspect_e o_aspect_c,
  output logic    o_tracked_nxt_c,
  output logic    o_seq_det_c,
  output logic    o_short_det_c
);

  trk_state_e        r_state;
  logic [CWIDTH-1:0] r_ycnt;

  aspect_e           w_aspect;
  trk_state_e        w_new;
  trk_state_e        w_state_nxt;
  logic [CWIDTH-1:0] w_ycnt_nxt;
  logic              w_seq;
  logic              w_short;

  // Dark/multi aspects hold the tracker; a valid aspect is checked against the held state.
  always_comb begin
    w_aspect    = decode_aspect(i_lamp);
    w_new       = aspect_to_state(w_aspect);
    w_state_nxt = r_state;
    w_ycnt_nxt  = r_ycnt;
    w_seq       = 1'b0;
    w_short     = 1'b0;
    if (w_new != TRK_UNK) begin
      w_state_nxt = w_new;
      if ((r_state != TRK_UNK) && (w_new != r_state) && !is_legal_step(r_state, w_new))
        w_seq = 1'b1;
      if ((r_state == TRK_YEL) && (w_new == TRK_RED) && (r_ycnt < CWIDTH'(YELLOW_MIN)))
        w_short = 1'b1;
      if (w_new == TRK_YEL) begin
        if (r_state != TRK_YEL)
          w_ycnt_nxt = CWIDTH'(1);
        else if (r_ycnt < CWIDTH'(YELLOW_MIN))
          w_ycnt_nxt = r_ycnt + CWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_state <= TRK_UNK;
      r_ycnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ycnt  <= w_ycnt_nxt;
    end
  end

  assign o_aspect_c      = w_aspect;
  assign o_tracked_nxt_c = (w_state_nxt != TRK_UNK) && !i_clr;
  assign o_seq_det_c     = w_seq;
  assign o_short_det_c   = w_short;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent lamp-output monitor: registers the six lamps, debounces lamp-level
// anomalies, tracks each approach and latches the first fault as a flash request.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_MIN = 500,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned CWIDTH     = 16
) (
  input logic                        clk,
  input logic                        rst,
  traffic_conflict_monitor_if.slave  bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  lamp_t            r_ns_q;
  lamp_t            r_ew_q;
  logic [DW-1:0]    r_db [AN_NUM];
  logic             r_fault;
  logic [2:0]       r_code;
  logic             r_ok;

  aspect_e          w_ns_aspect;
  aspect_e          w_ew_aspect;
  logic             w_ns_tracked;
  logic             w_ew_tracked;
  logic             w_ns_seq;
  logic             w_ew_seq;
  logic             w_ns_short;
  logic             w_ew_short;
  logic [AN_NUM-1:0] w_present;
  logic [AN_NUM-1:0] w_lamp_det;
  fault_code_e      w_code;
  logic             w_det;

  always_ff @(posedge clk) begin
    if (rst || bus.fault_clr) begin
      r_ns_q <= '0;
      r_ew_q <= '0;
    end else begin
      r_ns_q <= {bus.ns_red, bus.ns_yellow, bus.ns_green};
      r_ew_q <= {bus.ew_red, bus.ew_yellow, bus.ew_green};
    end
  end

  traffic_approach_tracker #(.YELLOW_MIN(YELLOW_MIN), .CWIDTH(CWIDTH)) u_ns (
    .clk             (clk),
    .rst             (rst),
    .i_clr           (bus.fault_clr),
    .i_lamp          (r_ns_q),
    .o_aspect_c      (w_ns_aspect),
    .o_tracked_nxt_c (w_ns_tracked),
    .o_seq_det_c     (w_ns_seq),
    .o_short_det_c   (w_ns_short)
  );

  traffic_approach_tracker #(.YELLOW_MIN(YELLOW_MIN), .CWIDTH(CWIDTH)) u_ew (
    .clk             (clk),
    .rst             (rst),
    .i_clr           (bus.fault_clr),
    .i_lamp          (r_ew_q),
    .o_aspect_c      (w_ew_aspect),
    .o_tracked_nxt_c (w_ew_tracked),
    .o_seq_det_c     (w_ew_seq),
    .o_short_det_c   (w_ew_short)
  );

  always_comb begin
    w_present              = '0;
    w_present[AN_CONFLICT] = (r_ns_q.green | r_ns_q.yellow) & (r_ew_q.green | r_ew_q.yellow);
    w_present[AN_MULTI]    = (w_ns_aspect == ASP_MULTI) || (w_ew_aspect == ASP_MULTI);
    w_present[AN_DARK]     = (w_ns_aspect == ASP_DARK) || (w_ew_aspect == ASP_DARK);
    for (int i = 0; i < AN_NUM; i++)
      w_lamp_det[i] = w_present[i] && (r_db[i] >= DW'(DEBOUNCE - 1));
  end

  // Run-length counters saturate at DEBOUNCE so a persisting anomaly keeps detecting.
  always_ff @(posedge clk) begin
    for (int i = 0; i < AN_NUM; i++) begin
      if (rst || bus.fault_clr || !w_present[i])
        r_db[i] <= '0;
      else if (r_db[i] != DW'(DEBOUNCE))
        r_db[i] <= r_db[i] + DW'(1);
    end
  end

  // Evaluated from highest to lowest code so the lowest code present wins.
  always_comb begin
    w_code = FC_NONE;
    if (w_ns_short || w_ew_short) w_code = FC_SHORT_Y;
    if (w_ns_seq || w_ew_seq)     w_code = FC_SEQ;
    if (w_lamp_det[AN_DARK])      w_code = FC_DARK;
    if (w_lamp_det[AN_MULTI])     w_code = FC_MULTI;
    if (w_lamp_det[AN_CONFLICT])  w_code = FC_CONFLICT;
    w_det = (w_code != FC_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.fault_clr) begin
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_ok    <= 1'b0;
    end else begin
      if (!r_fault && w_det) begin
        r_fault <= 1'b1;
        r_code  <= w_code;
      end
      r_ok <= !(r_fault || w_det) && w_ns_tracked && w_ew_tracked;
    end
  end

  assign bus.fault      = r_fault;
  assign bus.fault_code = r_code;
  assign bus.flash_en   = r_fault;
  assign bus.monitor_ok = r_ok;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with a per-cycle behavioural model
// of the lamp history and a few pinned literal expectations.
module tb_traffic_conflict_monitor;

  localparam int YMIN = 5;
  localparam int DEB  = 3;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(.YELLOW_MIN(YMIN), .DEBOUNCE(DEB), .CWIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Aspect as a number: 0 R, 1 Y, 2 G, 3 dark, 4 multi.
  function automatic int asp(input logic [2:0] l);
    case (l)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      3'b000:  return 3;
      default: return 4;
    endcase
  endfunction

  // Model state: registered lamps, last valid aspect (-1 unknown), yellow run, anomaly runs.
  logic [2:0] m_q [2];
  int         m_last [2];
  int         m_ylen [2];
  int         m_run [3];
  bit         m_fault;
  int         m_code;
  bit         m_started = 1'b0;

  always @(posedge clk) begin
    int a [2];
    int det;
    bit pres [3];
    m_started = 1'b1;
    if (rst || bus.fault_clr) begin
      for (int j = 0; j < 2; j++) begin
        m_last[j] = -1;
        m_ylen[j] = 0;
        m_q[j]    = 3'b000;
      end
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_fault = 1'b0;
      m_code  = 0;
    end else begin
      det = 99;
      for (int j = 0; j < 2; j++) a[j] = asp(m_q[j]);
      pres[0] = (m_q[0][1] | m_q[0][0]) & (m_q[1][1] | m_q[1][0]);
      pres[1] = (a[0] == 4) || (a[1] == 4);
      pres[2] = (a[0] == 3) || (a[1] == 3);
      for (int i = 0; i < 3; i++) begin
        m_run[i] = pres[i] ? m_run[i] + 1 : 0;
        if (m_run[i] >= DEB && (i + 1) < det) det = i + 1;
      end
      for (int j = 0; j < 2; j++) begin
        if (a[j] < 3) begin
          if (m_last[j] >= 0) begin
            if (a[j] != m_last[j] && a[j] != (m_last[j] + 2) % 3 && det > 4) det = 4;
            if (m_last[j] == 1 && a[j] == 0 && m_ylen[j] < YMIN && det > 5) det = 5;
          end
          if (a[j] == 1) m_ylen[j] = (m_last[j] == 1) ? m_ylen[j] + 1 : 1;
          m_last[j] = a[j];
        end
      end
      if (!m_fault && det != 99) begin
        m_fault = 1'b1;
        m_code  = det;
      end
      m_q[0] = {bus.ns_red, bus.ns_yellow, bus.ns_green};
      m_q[1] = {bus.ew_red, bus.ew_yellow, bus.ew_green};
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("fault", int'(bus.fault), int'(m_fault));
      chk("fault_code", int'(bus.fault_code), m_code);
      chk("flash_en", int'(bus.flash_en), int'(m_fault));
      chk("monitor_ok", int'(bus.monitor_ok),
          int'(!m_fault && m_last[0] >= 0 && m_last[1] >= 0));
    end
  end

  task automatic set(input logic [2:0] ns, input logic [2:0] ew);
    {bus.ns_red, bus.ns_yellow, bus.ns_green} = ns;
    {bus.ew_red, bus.ew_yellow, bus.ew_green} = ew;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_with(input logic [2:0] ns, input logic [2:0] ew);
    bus.fault_clr = 1'b1;
    set(ns, ew);
    cyc(1);
    bus.fault_clr = 1'b0;
  endtask

  initial begin
    bus.fault_clr = 1'b0;
    set(R, R);
    rst = 1'b1;
    cyc(2);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_code", int'(bus.fault_code), 0);
    chk("rst_ok", int'(bus.monitor_ok), 0);

    // Release with NS green / EW red; ok rises after the second edge.
    set(G, R);
    rst = 1'b0;
    cyc(1);
    chk("ok_edge1", int'(bus.monitor_ok), 0);
    cyc(1);
    chk("ok_edge2", int'(bus.monitor_ok), 1);

    for (int r = 0; r < 2; r++) begin
      set(G, R); cyc(10);
      set(Y, R); cyc(5);
      set(R, G); cyc(10);
      set(R, Y); cyc(5);
    end
    set(G, R); cyc(5);
    set(Y, R); cyc(5);
    chk("normal_rounds", int'(bus.fault), 0);

    // Two-cycle overlap of NS yellow and EW green is tolerated.
    set(Y, G); cyc(2);
    set(R, G); cyc(6);
    chk("conflict_2cyc", int'(bus.fault), 0);

    set(R, Y); cyc(5);
    set(G, Y); cyc(3);
    chk("conflict_k2", int'(bus.fault), 0);
    cyc(1);
    chk("conflict_fault", int'(bus.fault), 1);
    chk("conflict_code", int'(bus.fault_code), 1);
    chk("conflict_flash", int'(bus.flash_en), 1);

    // Clear, then start NS directly in yellow.
    clr_with(Y, R);
    chk("clr_fault", int'(bus.fault), 0);
    chk("clr_code", int'(bus.fault_code), 0);
    chk("clr_flash", int'(bus.flash_en), 0);
    chk("clr_ok", int'(bus.monitor_ok), 0);
    cyc(5);
    set(R, R); cyc(2);
    chk("clr_yellow_ok", int'(bus.fault), 0);

    // Four-cycle yellow.
    set(G, R); cyc(3);
    set(Y, R); cyc(4);
    set(R, R); cyc(1);
    chk("short_k", int'(bus.fault), 0);
    cyc(1);
    chk("short_code", int'(bus.fault_code), 5);

    // Green straight to red.
    clr_with(G, R); cyc(4);
    set(R, R); cyc(1);
    chk("seq_k", int'(bus.fault), 0);
    cyc(1);
    chk("seq_code", int'(bus.fault_code), 4);

    // SEQ on NS coincides with third dark cycle on EW.
    clr_with(G, R); cyc(4);
    set(G, D); cyc(2);
    set(R, D); cyc(1);
    chk("dark_k2", int'(bus.fault), 0);
    cyc(1);
    chk("dark_seq_code", int'(bus.fault_code), 3);
    set(G, G); cyc(4);
    chk("dark_frozen", int'(bus.fault_code), 3);

    // Reset during NS yellow, release into red.
    clr_with(G, R); cyc(3);
    set(Y, R); cyc(2);
    rst = 1'b1; cyc(2);
    set(R, R);
    rst = 1'b0; cyc(3);
    chk("rst_mid_yel", int'(bus.fault), 0);
    set(G, R); cyc(3);
    set(Y, R); cyc(5);
    set(R, R); cyc(3);
    chk("post_rst_fault", int'(bus.fault), 0);
    chk("post_rst_ok", int'(bus.monitor_ok), 1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
